// File: rtl/enc_seq_ctrl.sv
// Encoder measurement sequencer: selects a Z reference, lets it settle, arms
// the encoder counters until both are ready (or an overflow / timeout occurs),
// captures the live counts and holds the result until the consumer acknowledges.
module enc_seq_ctrl #(
    parameter int CNT_W  = 64,
    parameter int TO_W   = 32,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             I_RST,
    input  logic             I_START,
    input  logic             I_SEL_CFG,
    input  logic [TO_W-1:0]  I_TIMEOUT,
    input  logic             I_READY_0,
    input  logic             I_READY_1,
    input  logic             I_OVERFLOW_0,
    input  logic             I_OVERFLOW_1,
    input  logic [CNT_W-1:0] I_CNT_A0,
    input  logic [CNT_W-1:0] I_CNT_A1,
    input  logic             I_RES_ACK,
    output logic             O_ARM,
    output logic             O_SEL,
    output logic             O_BUSY,
    output logic             O_RES_VALID,
    output logic [CNT_W-1:0] O_RES_CNT_A0,
    output logic [CNT_W-1:0] O_RES_CNT_A1,
    output logic [2:0]       O_STATUS,
    output logic             O_DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);

    state_t          state;
    state_t          next_state;
    logic [3:0]      settle_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] limit;
    logic            rdy0;
    logic            rdy1;
    logic            ovf0;
    logic            ovf1;
    logic            to_flag;

    // Flags as they will be after this cycle's sampling, so an exit can be
    // taken in the same cycle a ready/overflow input is first seen.
    logic rdy0_now;
    logic rdy1_now;
    logic ovf0_now;
    logic ovf1_now;
    logic to_hit;
    logic capture_req;

    // Exit-condition evaluation for the ARMED phase
    always_comb begin
        rdy0_now    = rdy0 | I_READY_0;
        rdy1_now    = rdy1 | I_READY_1;
        ovf0_now    = ovf0 | I_OVERFLOW_0;
        ovf1_now    = ovf1 | I_OVERFLOW_1;
        to_hit      = (limit != '0) && (to_cnt == (limit - TO_ONE));
        capture_req = (rdy0_now & rdy1_now) | ovf0_now | ovf1_now | to_hit;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (I_RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (I_START) next_state = SETUP;
            SETUP:   if (settle_cnt == SETTLE_LAST) next_state = ARMED;
            ARMED:   if (capture_req) next_state = CAPTURE;
            CAPTURE: next_state = HOLD;
            HOLD:    if (I_RES_ACK) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Combinational outputs derived from the state register and flags
    always_comb begin
        O_BUSY   = (state != IDLE);
        O_STATUS = {to_flag, ovf1, ovf0};
    end

    // Registered outputs, run configuration, counters and sticky flags.
    // ARM/VALID/DONE are decoded from next_state so they are flop outputs
    // that line up exactly with the state they describe.
    always_ff @(posedge CLK) begin
        if (I_RST) begin
            O_ARM        <= 1'b0;
            O_SEL        <= 1'b0;
            O_RES_VALID  <= 1'b0;
            O_DONE       <= 1'b0;
            O_RES_CNT_A0 <= '0;
            O_RES_CNT_A1 <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            limit        <= '0;
            rdy0         <= 1'b0;
            rdy1         <= 1'b0;
            ovf0         <= 1'b0;
            ovf1         <= 1'b0;
            to_flag      <= 1'b0;
        end else begin
            O_ARM       <= (next_state == ARMED);
            O_RES_VALID <= (next_state == HOLD);
            O_DONE      <= (next_state == HOLD) && (state != HOLD);
            case (state)
                IDLE: begin
                    if (I_START) begin
                        O_SEL      <= I_SEL_CFG;
                        limit      <= I_TIMEOUT;
                        settle_cnt <= '0;
                        to_cnt     <= '0;
                        rdy0       <= 1'b0;
                        rdy1       <= 1'b0;
                        ovf0       <= 1'b0;
                        ovf1       <= 1'b0;
                        to_flag    <= 1'b0;
                    end
                end
                SETUP: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    to_cnt     <= '0;
                end
                ARMED: begin
                    rdy0 <= rdy0_now;
                    rdy1 <= rdy1_now;
                    ovf0 <= ovf0_now;
                    ovf1 <= ovf1_now;
                    if (to_hit) to_flag <= 1'b1;
                    if (to_cnt != '1) to_cnt <= to_cnt + TO_ONE;
                end
                CAPTURE: begin
                    O_RES_CNT_A0 <= I_CNT_A0;
                    O_RES_CNT_A1 <= I_CNT_A1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_seq_ctrl.sv
// Directed bench for enc_seq_ctrl: expected results are queued when a run's
// exit stimulus is driven and compared when the DUT pulses O_DONE.
module tb_enc_seq_ctrl;

    localparam int CNT_W  = 64;
    localparam int TO_W   = 32;
    localparam int SETTLE = 2;

    logic             CLK = 1'b0;
    logic             I_RST;
    logic             I_START;
    logic             I_SEL_CFG;
    logic [TO_W-1:0]  I_TIMEOUT;
    logic             I_READY_0;
    logic             I_READY_1;
    logic             I_OVERFLOW_0;
    logic             I_OVERFLOW_1;
    logic [CNT_W-1:0] I_CNT_A0;
    logic [CNT_W-1:0] I_CNT_A1;
    logic             I_RES_ACK;
    logic             O_ARM;
    logic             O_SEL;
    logic             O_BUSY;
    logic             O_RES_VALID;
    logic [CNT_W-1:0] O_RES_CNT_A0;
    logic [CNT_W-1:0] O_RES_CNT_A1;
    logic [2:0]       O_STATUS;
    logic             O_DONE;

    typedef struct {
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c1;
        logic [2:0]       st;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    enc_seq_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .SETTLE(SETTLE)) dut (
        .CLK          (CLK),
        .I_RST        (I_RST),
        .I_START      (I_START),
        .I_SEL_CFG    (I_SEL_CFG),
        .I_TIMEOUT    (I_TIMEOUT),
        .I_READY_0    (I_READY_0),
        .I_READY_1    (I_READY_1),
        .I_OVERFLOW_0 (I_OVERFLOW_0),
        .I_OVERFLOW_1 (I_OVERFLOW_1),
        .I_CNT_A0     (I_CNT_A0),
        .I_CNT_A1     (I_CNT_A1),
        .I_RES_ACK    (I_RES_ACK),
        .O_ARM        (O_ARM),
        .O_SEL        (O_SEL),
        .O_BUSY       (O_BUSY),
        .O_RES_VALID  (O_RES_VALID),
        .O_RES_CNT_A0 (O_RES_CNT_A0),
        .O_RES_CNT_A1 (O_RES_CNT_A1),
        .O_STATUS     (O_STATUS),
        .O_DONE       (O_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic sel, input logic [TO_W-1:0] tmo);
        I_SEL_CFG = sel;
        I_TIMEOUT = tmo;
        I_START   = 1'b1;
        tick();
        I_START   = 1'b0;
        tick();
        tick();
    endtask

    // Scoreboard: every DONE pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (O_DONE === 1'b1) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_cnt_a0", O_RES_CNT_A0, e.c0);
                chk("sb_cnt_a1", O_RES_CNT_A1, e.c1);
                chk("sb_status", 64'(O_STATUS), 64'(e.st));
                chk("sb_valid", 64'(O_RES_VALID), 64'd1);
            end
        end
    end

    initial begin
        I_RST = 1'b1; I_START = 1'b0; I_SEL_CFG = 1'b0; I_TIMEOUT = '0;
        I_READY_0 = 1'b0; I_READY_1 = 1'b0; I_OVERFLOW_0 = 1'b0; I_OVERFLOW_1 = 1'b0;
        I_CNT_A0 = '0; I_CNT_A1 = '0; I_RES_ACK = 1'b0;
        tick();
        tick();
        chk("rst_arm", 64'(O_ARM), 64'd0);
        chk("rst_busy", 64'(O_BUSY), 64'd0);
        chk("rst_valid", 64'(O_RES_VALID), 64'd0);
        chk("rst_status", 64'(O_STATUS), 64'd0);
        I_RST = 1'b0;

        // Run 1: SEL=1, both readies at ARMED cycles 5 and 9
        I_CNT_A0 = 64'h1234;
        I_CNT_A1 = 64'hABCD;
        I_SEL_CFG = 1'b1;
        I_START = 1'b1;
        I_RES_ACK = 1'b1;
        tick();
        chk("start_sel", 64'(O_SEL), 64'd1);
        chk("start_busy", 64'(O_BUSY), 64'd1);
        chk("setup1_arm", 64'(O_ARM), 64'd0);
        I_START = 1'b0;
        I_RES_ACK = 1'b0;
        I_SEL_CFG = 1'b0;
        tick();
        chk("setup2_arm", 64'(O_ARM), 64'd0);
        tick();
        chk("arm_latency", 64'(O_ARM), 64'd1);
        for (int c = 1; c <= 9; c++) begin
            chk("armed_arm", 64'(O_ARM), 64'd1);
            chk("armed_sel", 64'(O_SEL), 64'd1);
            I_READY_0 = (c == 5);
            I_READY_1 = (c == 9);
            I_RES_ACK = (c == 3);
            I_START   = (c == 4);
            if (c == 9) sb.push_back('{64'h1234, 64'hABCD, 3'b000});
            tick();
        end
        I_READY_0 = 1'b0; I_READY_1 = 1'b0; I_RES_ACK = 1'b0; I_START = 1'b0;
        chk("capture_arm", 64'(O_ARM), 64'd0);
        chk("capture_valid", 64'(O_RES_VALID), 64'd0);
        tick();
        chk("hold_valid", 64'(O_RES_VALID), 64'd1);
        chk("hold_done", 64'(O_DONE), 64'd1);
        I_CNT_A0 = 64'h5555;
        I_CNT_A1 = 64'h6666;
        I_START = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid_stay", 64'(O_RES_VALID), 64'd1);
            chk("hold_done_once", 64'(O_DONE), 64'd0);
            chk("hold_frozen_a0", O_RES_CNT_A0, 64'h1234);
            chk("hold_frozen_a1", O_RES_CNT_A1, 64'hABCD);
            chk("hold_sel", 64'(O_SEL), 64'd1);
        end
        I_START = 1'b0;
        I_RES_ACK = 1'b1;
        tick();
        I_RES_ACK = 1'b0;
        chk("ack_valid", 64'(O_RES_VALID), 64'd0);
        chk("ack_busy", 64'(O_BUSY), 64'd0);

        // Run 2: timeout of 10 with no readies
        I_CNT_A0 = 64'd5;
        I_CNT_A1 = 64'd7;
        sb.push_back('{64'd5, 64'd7, 3'b100});
        start_run(1'b0, 32'd10);
        n = 0;
        while (O_ARM === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_arm_cycles", 64'(n), 64'd10);
        chk("timeout_sel", 64'(O_SEL), 64'd0);
        tick();
        chk("timeout_valid", 64'(O_RES_VALID), 64'd1);
        chk("timeout_status", 64'(O_STATUS), 64'b100);
        I_RES_ACK = 1'b1;
        tick();
        I_RES_ACK = 1'b0;

        // Run 3: overflow_1 and ready_0 in the same ARMED cycle
        I_CNT_A0 = 64'h11;
        I_CNT_A1 = 64'h22;
        start_run(1'b0, 32'd0);
        chk("ovf_armed", 64'(O_ARM), 64'd1);
        tick();
        tick();
        I_OVERFLOW_1 = 1'b1;
        I_READY_0 = 1'b1;
        I_START = 1'b1;
        sb.push_back('{64'h11, 64'h22, 3'b010});
        tick();
        I_OVERFLOW_1 = 1'b0; I_READY_0 = 1'b0; I_START = 1'b0;
        chk("ovf_capture_arm", 64'(O_ARM), 64'd0);
        chk("ovf_capture_busy", 64'(O_BUSY), 64'd1);
        tick();
        chk("ovf_valid", 64'(O_RES_VALID), 64'd1);
        chk("ovf_status", 64'(O_STATUS), 64'b010);
        I_RES_ACK = 1'b1;
        tick();
        I_RES_ACK = 1'b0;

        // Run 4: timeout disabled, 1000 idle ARMED cycles, then reset abort
        start_run(1'b1, 32'd0);
        repeat (1000) tick();
        chk("notimeout_arm", 64'(O_ARM), 64'd1);
        chk("notimeout_busy", 64'(O_BUSY), 64'd1);
        chk("notimeout_sel", 64'(O_SEL), 64'd1);
        I_RST = 1'b1;
        I_START = 1'b1;
        I_READY_0 = 1'b1;
        I_READY_1 = 1'b1;
        tick();
        chk("abort_arm", 64'(O_ARM), 64'd0);
        chk("abort_busy", 64'(O_BUSY), 64'd0);
        chk("abort_sel", 64'(O_SEL), 64'd0);
        chk("abort_valid", 64'(O_RES_VALID), 64'd0);
        chk("abort_done", 64'(O_DONE), 64'd0);
        chk("abort_status", 64'(O_STATUS), 64'd0);
        chk("abort_cnt_a0", O_RES_CNT_A0, 64'd0);
        chk("abort_cnt_a1", O_RES_CNT_A1, 64'd0);
        I_RST = 1'b0; I_START = 1'b0; I_READY_0 = 1'b0; I_READY_1 = 1'b0;
        tick();
        chk("abort_idle", 64'(O_BUSY), 64'd0);

        // Run 5: fresh run after reset, both readies together
        I_CNT_A0 = 64'hDEAD;
        I_CNT_A1 = 64'hBEEF;
        start_run(1'b0, 32'd50);
        chk("rerun_arm", 64'(O_ARM), 64'd1);
        I_READY_0 = 1'b1;
        I_READY_1 = 1'b1;
        sb.push_back('{64'hDEAD, 64'hBEEF, 3'b000});
        tick();
        I_READY_0 = 1'b0; I_READY_1 = 1'b0;
        chk("rerun_capture", 64'(O_ARM), 64'd0);
        tick();
        chk("rerun_valid", 64'(O_RES_VALID), 64'd1);
        chk("rerun_done", 64'(O_DONE), 64'd1);
        I_RES_ACK = 1'b1;
        tick();
        I_RES_ACK = 1'b0;
        chk("rerun_ack", 64'(O_RES_VALID), 64'd0);

        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
